// File: rtl/hazard_ctrl.sv
// hazard_ctrl: D-stage stall and forwarding-select generation from shadow E/M/W register-use records.
module hazard_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] d_A1,
    input  logic [4:0] d_A2,
    input  logic [4:0] d_A3,
    input  logic [2:0] d_Tnew,
    input  logic [2:0] d_Tuse1,
    input  logic [2:0] d_Tuse2,
    output logic       stall,
    output logic [1:0] fwd_rs_D,
    output logic [1:0] fwd_rt_D,
    output logic [1:0] fwd_rs_E,
    output logic [1:0] fwd_rt_E,
    output logic       fwd_rt_M
);
    logic [4:0] r_e_a1, r_e_a2, r_e_a3, r_m_a2, r_m_a3, r_w_a3;
    logic [2:0] r_e_tnew, r_m_tnew, r_w_tnew;
    logic       w_stall_rs, w_stall_rt;

    function automatic logic [2:0] sat(input logic [2:0] x);
        return (x == 3'd0) ? 3'd0 : x - 3'd1;
    endfunction

    function automatic logic hit(input logic [4:0] a3, input logic [2:0] tnew, input logic [4:0] src);
        return (a3 != 5'd0) && (a3 == src) && (tnew == 3'd0);
    endfunction

    function automatic logic busy(input logic [4:0] src, input logic [2:0] tuse,
                                  input logic [4:0] ea3, input logic [2:0] etn,
                                  input logic [4:0] ma3, input logic [2:0] mtn);
        return (src != 5'd0) && ((ea3 == src && etn > tuse) || (ma3 == src && mtn > tuse));
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            r_e_a1   <= '0;
            r_e_a2   <= '0;
            r_e_a3   <= '0;
            r_e_tnew <= '0;
            r_m_a2   <= '0;
            r_m_a3   <= '0;
            r_m_tnew <= '0;
            r_w_a3   <= '0;
            r_w_tnew <= '0;
        end else begin
            r_e_a1   <= stall ? 5'd0 : d_A1;
            r_e_a2   <= stall ? 5'd0 : d_A2;
            r_e_a3   <= stall ? 5'd0 : d_A3;
            r_e_tnew <= stall ? 3'd0 : sat(d_Tnew);
            r_m_a2   <= r_e_a2;
            r_m_a3   <= r_e_a3;
            r_m_tnew <= sat(r_e_tnew);
            r_w_a3   <= r_m_a3;
            r_w_tnew <= sat(r_m_tnew);
        end
    end

    // W is never checked for stall: its Tnew has always aged to zero.
    always_comb begin
        w_stall_rs = busy(d_A1, d_Tuse1, r_e_a3, r_e_tnew, r_m_a3, r_m_tnew);
        w_stall_rt = busy(d_A2, d_Tuse2, r_e_a3, r_e_tnew, r_m_a3, r_m_tnew);
        stall      = !reset && (w_stall_rs || w_stall_rt);
        fwd_rs_D   = reset ? 2'd0 : hit(r_e_a3, r_e_tnew, d_A1) ? 2'd1 :
                     hit(r_m_a3, r_m_tnew, d_A1) ? 2'd2 : hit(r_w_a3, r_w_tnew, d_A1) ? 2'd3 : 2'd0;
        fwd_rt_D   = reset ? 2'd0 : hit(r_e_a3, r_e_tnew, d_A2) ? 2'd1 :
                     hit(r_m_a3, r_m_tnew, d_A2) ? 2'd2 : hit(r_w_a3, r_w_tnew, d_A2) ? 2'd3 : 2'd0;
        fwd_rs_E   = reset ? 2'd0 : hit(r_m_a3, r_m_tnew, r_e_a1) ? 2'd1 :
                     hit(r_w_a3, r_w_tnew, r_e_a1) ? 2'd2 : 2'd0;
        fwd_rt_E   = reset ? 2'd0 : hit(r_m_a3, r_m_tnew, r_e_a2) ? 2'd1 :
                     hit(r_w_a3, r_w_tnew, r_e_a2) ? 2'd2 : 2'd0;
        fwd_rt_M   = !reset && hit(r_w_a3, r_w_tnew, r_m_a2);
    end
endmodule
